block_chain_sequencer: RTL

BLOCK_CHAIN_SEQUENCER -- requirements
Module: block_chain_sequencer

---
 rtl/block_chain_sequencer_pkg.sv | 21 ++
 rtl/sequencer_fifo.sv | 43 ++++
 rtl/block_chain_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/block_chain_sequencer_pkg.sv
// Shared types for the block chain sequencer.
//   DEF_BLOCK_W    default cipher block width
//   seq_state_e    sequencer FSM states
//   queue_entry_t  queue entry {encrypt, data} at the default width
package block_chain_sequencer_pkg;

    localparam int DEF_BLOCK_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_CORE,
        ST_HOLD
    } seq_state_e;

    typedef struct packed {
        logic                   encrypt;
        logic [DEF_BLOCK_W-1:0] data;
    } queue_entry_t;

endpackage

// File: rtl/sequencer_fifo.sv
// sequencer_fifo: DEPTH-entry synchronous FIFO.
//   clk, n_rst       clock, async active-low reset
//   push, push_data  write strobe/data (ignored while full)
//   pop, pop_data    read strobe (ignored while empty), head entry (show-ahead)
//   full, empty      occupancy flags
module sequencer_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // Extra MSB on each pointer separates full (MSBs differ) from empty.
    logic [AW:0]  wr_ptr, rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/block_chain_sequencer.sv
// block_chain_sequencer: queues blocks and feeds them one at a time through
// an external cipher core, presenting each result with a valid/ack handshake.
// Optional feature macro: CBC_CHAIN_EN (CBC chaining; ECB when undefined).
// Ports:
//   clk, n_rst                        clock, async active-low reset
//   rcv_data_ready, rcv_data, encrypt input block push
//   iv_load, iv_data                  chain register load (idle + empty only)
//   core_start/core_mode/core_data_in request to the cipher core
//   core_data_out, core_done          response from the cipher core
//   trans_data, trans_data_ready      result, held until handshake_ack
//   queue_full, overflow, busy        status (overflow is sticky)
module block_chain_sequencer
    import block_chain_sequencer_pkg::*;
#(
    parameter int BLOCK_W = DEF_BLOCK_W,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               rcv_data_ready,
    input  logic [BLOCK_W-1:0] rcv_data,
    input  logic               encrypt,
    input  logic               iv_load,
    input  logic [BLOCK_W-1:0] iv_data,
    output logic               core_start,
    output logic               core_mode,
    output logic [BLOCK_W-1:0] core_data_in,
    input  logic [BLOCK_W-1:0] core_data_out,
    input  logic               core_done,
    output logic [BLOCK_W-1:0] trans_data,
    output logic               trans_data_ready,
    input  logic               handshake_ack,
    output logic               queue_full,
    output logic               overflow,
    output logic               busy
);
    // Same layout as queue_entry_t, sized by BLOCK_W.
    typedef struct packed {
        logic               encrypt;
        logic [BLOCK_W-1:0] data;
    } entry_t;

    seq_state_e state;
    entry_t     push_ent, head, work;
    logic       q_empty, pop;

    assign push_ent = '{encrypt: encrypt, data: rcv_data};
    assign pop      = (state == ST_IDLE) && !q_empty;
    assign busy     = (state != ST_IDLE) || !q_empty;

    sequencer_fifo #(.W(BLOCK_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (rcv_data_ready),
        .push_data (push_ent),
        .pop       (pop),
        .pop_data  (head),
        .full      (queue_full),
        .empty     (q_empty)
    );

`ifdef CBC_CHAIN_EN
    logic [BLOCK_W-1:0] chain;
`else
    logic unused_ecb;
    assign unused_ecb = ^{iv_load, iv_data, work};
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= ST_IDLE;
            work             <= '0;
            core_start       <= 1'b0;
            core_mode        <= 1'b0;
            core_data_in     <= '0;
            trans_data       <= '0;
            trans_data_ready <= 1'b0;
            overflow         <= 1'b0;
`ifdef CBC_CHAIN_EN
            chain            <= '0;
`endif
        end else begin
            core_start <= 1'b0;
            if (rcv_data_ready && queue_full) overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        // Pop and launch together so core_start is high
                        // exactly for the single ISSUE cycle.
                        work       <= head;
                        core_mode  <= head.encrypt;
                        core_start <= 1'b1;
`ifdef CBC_CHAIN_EN
                        core_data_in <= head.encrypt ? (head.data ^ chain) : head.data;
`else
                        core_data_in <= head.data;
`endif
                        state <= ST_ISSUE;
                    end
`ifdef CBC_CHAIN_EN
                    else if (iv_load) begin
                        chain <= iv_data;
                    end
`endif
                end
                ST_ISSUE: state <= ST_WAIT_CORE;
                ST_WAIT_CORE: begin
                    if (core_done) begin
`ifdef CBC_CHAIN_EN
                        if (work.encrypt) begin
                            trans_data <= core_data_out;
                            chain      <= core_data_out;
                        end else begin
                            trans_data <= core_data_out ^ chain;
                            chain      <= work.data;
                        end
`else
                        trans_data <= core_data_out;
`endif
                        trans_data_ready <= 1'b1;
                        state            <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (handshake_ack) begin
                        trans_data_ready <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
